// File: rtl/fdiv16.sv
// Multi-cycle binary16 divider: restoring radix-2 divide, one rounding cycle, DONE handshake.
// Define FDIV16_EARLY_EXIT_EN to send special operands straight from IDLE to DONE.
module fdiv16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  roundmode,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {StIdle, StDiv, StRnd, StDone} state_e;

    typedef struct packed {
        logic        hit;
        logic [3:0]  flg;
        logic [15:0] res;
    } spec_t;

    // Special-operand outcome; subnormals count as zero.
    function automatic spec_t classify(input logic [15:0] a, input logic [15:0] b);
        spec_t s;
        logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        a_zero = (a[14:10] == 5'h00);
        b_zero = (b[14:10] == 5'h00);
        sgn    = a[15] ^ b[15];
        s.hit  = 1'b1;
        s.flg  = 4'b0000;
        s.res  = {sgn, 15'h0000};
        if (a_nan || b_nan) begin
            s.res = 16'h7E00;
            s.flg = {(a_nan & ~a[9]) | (b_nan & ~b[9]), 3'b000};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            s.res = 16'h7E00;
            s.flg = 4'b1000;
        end else if (a_inf || b_zero) begin
            s.res = {sgn, 5'h1F, 10'h000};
        end else if (b_inf || a_zero) begin
            s.res = {sgn, 15'h0000};
        end else begin
            s.hit = 1'b0;
        end
        return s;
    endfunction

    state_e       state_q, state_d;
    logic [15:0]  x_q, x_d, y_q, y_d;
    logic [1:0]   rm_q, rm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [11:0]  rem_q, rem_d;
    logic [12:0]  quo_q, quo_d;
    logic [15:0]  result_q, result_d;
    logic [3:0]   flags_q, flags_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            x_q      <= 16'h0000;
            y_q      <= 16'h0000;
            rm_q     <= 2'b00;
            cnt_q    <= 4'd0;
            rem_q    <= 12'h000;
            quo_q    <= 13'h0000;
            result_q <= 16'h0000;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rm_q     <= rm_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // One restoring step per DIV cycle.
    logic [11:0] dsig;
    logic        rem_ge;
    logic [11:0] rem_sub;

    always_comb begin
        dsig    = {2'b01, y_q[9:0]};
        rem_ge  = (rem_q >= dsig);
        rem_sub = rem_ge ? (rem_q - dsig) : rem_q;
    end

    // Normalise and round the finished quotient.
    logic               sgn, guard, sticky, inc, nx, to_inf;
    logic [10:0]        sig, sig_rnd;
    logic signed [6:0]  exp_raw, exp_n, exp_f;
    logic [15:0]        rnd_res;
    logic [3:0]         rnd_flg;
    spec_t              op_spec;

    always_comb begin
        sgn     = x_q[15] ^ y_q[15];
        exp_raw = $signed({2'b00, x_q[14:10]}) - $signed({2'b00, y_q[14:10]}) + 7'sd15;
        if (quo_q[12]) begin
            sig    = quo_q[12:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != 12'h000);
            exp_n  = exp_raw;
        end else begin
            sig    = quo_q[11:1];
            guard  = quo_q[0];
            sticky = (rem_q != 12'h000);
            exp_n  = exp_raw - 7'sd1;
        end
        nx  = guard | sticky;
        inc = 1'b0;
        unique case (rm_q)
            2'b00: inc = 1'b0;
            2'b01: inc = guard & (sticky | sig[0]);
            2'b10: inc = nx & sgn;
            2'b11: inc = nx & ~sgn;
        endcase
        // sig always has its top bit set, so a cleared top bit after the add means carry-out.
        sig_rnd = sig + {10'h000, inc};
        exp_f   = sig_rnd[10] ? exp_n : (exp_n + 7'sd1);
        to_inf  = (rm_q == 2'b01) || (rm_q == 2'b11 && !sgn) || (rm_q == 2'b10 && sgn);
        if (exp_f > 7'sd30) begin
            rnd_res = to_inf ? {sgn, 5'h1F, 10'h000} : {sgn, 5'h1E, 10'h3FF};
            rnd_flg = 4'b0101;
        end else if (exp_f < 7'sd1) begin
            rnd_res = {sgn, 15'h0000};
            rnd_flg = 4'b0011;
        end else begin
            rnd_res = {sgn, exp_f[4:0], sig_rnd[9:0]};
            rnd_flg = {3'b000, nx};
        end
        op_spec = classify(x_q, y_q);
    end

`ifdef FDIV16_EARLY_EXIT_EN
    spec_t in_spec;
    always_comb in_spec = classify(x, y);
`endif

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rm_d     = rm_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d   = x;
                    y_d   = y;
                    rm_d  = roundmode;
                    cnt_d = 4'd0;
`ifdef FDIV16_EARLY_EXIT_EN
                    if (in_spec.hit) begin
                        state_d  = StDone;
                        result_d = in_spec.res;
                        flags_d  = in_spec.flg;
                    end else begin
                        state_d = StDiv;
                    end
`else
                    state_d = StDiv;
`endif
                end
            end
            StDiv: begin
                // Count 0 is the entry cycle that loads the dividend; 1..13 yield q[12:0].
                if (cnt_q == 4'd0) begin
                    rem_d = {1'b0, 1'b1, x_q[9:0]};
                    quo_d = 13'h0000;
                end else begin
                    rem_d = rem_sub << 1;
                    quo_d = {quo_q[11:0], rem_ge};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = StRnd;
                end
            end
            StRnd: begin
                state_d  = StDone;
                result_d = op_spec.hit ? op_spec.res : rnd_res;
                flags_d  = op_spec.hit ? op_spec.flg : rnd_flg;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
